// File: rtl/tlb_refill_server_pkg.sv
`default_nettype none
// tlb_refill_server_pkg -- TLB geometry, entry layout and refill FSM state type. Rev 1.0
package tlb_refill_server_pkg;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = $clog2(TLBNUM);
  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;
  localparam int LO_W   = PFN_W + C_W + 3;

  localparam logic [C_W-1:0] C_CACHEABLE = 3'b011;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } tlb_half_t;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    tlb_half_t         lo0;
    tlb_half_t         lo1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOK = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // EntryLo layout is {PFN, C, D, V, G}; the entry is global only if both halves say so.
  function automatic tlb_entry_t make_entry(input logic [VPN2_W-1:0] vpn2,
                                            input logic [ASID_W-1:0] asid,
                                            input logic [LO_W-1:0]   lo0,
                                            input logic [LO_W-1:0]   lo1);
    tlb_entry_t e;
    e.vpn2 = vpn2;
    e.asid = asid;
    e.g    = lo0[0] & lo1[0];
    e.lo0  = tlb_half_t'(lo0[LO_W-1:1]);
    e.lo1  = tlb_half_t'(lo1[LO_W-1:1]);
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_refill_server_if.sv
`default_nettype none
// tlb_refill_server_if -- ITLB/DTLB buffer refill request/response bundle. Rev 1.0
interface tlb_refill_server_if;
  import tlb_refill_server_pkg::*;

  logic              i_req;
  logic              d_req;
  logic [VPN2_W-1:0] i_vpn2;
  logic [VPN2_W-1:0] d_vpn2;
  logic              i_resp_valid;
  logic              d_resp_valid;
  logic              resp_found;
  logic [IDX_W-1:0]  resp_index;
  logic [PFN_W-1:0]  resp_pfn0;
  logic [PFN_W-1:0]  resp_pfn1;
  logic [C_W-1:0]    resp_c0;
  logic [C_W-1:0]    resp_c1;
  logic              resp_d0;
  logic              resp_v0;
  logic              resp_d1;
  logic              resp_v1;

  modport master (
    output i_req, d_req, i_vpn2, d_vpn2,
    input  i_resp_valid, d_resp_valid, resp_found, resp_index,
           resp_pfn0, resp_pfn1, resp_c0, resp_c1,
           resp_d0, resp_v0, resp_d1, resp_v1
  );

  modport slave (
    input  i_req, d_req, i_vpn2, d_vpn2,
    output i_resp_valid, d_resp_valid, resp_found, resp_index,
           resp_pfn0, resp_pfn1, resp_c0, resp_c1,
           resp_d0, resp_v0, resp_d1, resp_v1
  );

endinterface
`default_nettype wire

// File: rtl/tlb_refill_server_match.sv
`default_nettype none
// tlb_match -- TLBNUM-way VPN2/ASID compare with lowest-index priority encode. Rev 1.0
module tlb_match
  import tlb_refill_server_pkg::*;
(
  input  logic [TLBNUM-1:0][VPN2_W-1:0] ent_vpn2,
  input  logic [TLBNUM-1:0][ASID_W-1:0] ent_asid,
  input  logic [TLBNUM-1:0]             ent_g,
  input  logic [VPN2_W-1:0]             vpn2,
  input  logic [ASID_W-1:0]             asid,
  output logic                          found,
  output logic [IDX_W-1:0]              index
);

  logic [TLBNUM-1:0] hit;

  generate
    for (genvar k = 0; k < TLBNUM; k++) begin : g_cmp
      assign hit[k] = (ent_vpn2[k] == vpn2) && (ent_g[k] || (ent_asid[k] == asid));
    end
  endgenerate

  // Scan downwards so the lowest matching index is the last one assigned.
  always_comb begin
    found = |hit;
    index = '0;
    for (int k = TLBNUM - 1; k >= 0; k--) begin
      if (hit[k]) begin
        index = IDX_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlb_refill_server.sv
`default_nettype none
// tlb_refill_server -- joint TLB, ITLB/DTLB refill responder and CP0 TLB ops. Rev 1.0
// TLB_RANDOM_WR_EN: tlbwr targets a free-running down-counter instead of cp0_index.
module tlb_refill_server
  import tlb_refill_server_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  tlb_refill_server_if.slave  bus,
  input  logic [ASID_W-1:0]   cp0_asid,
  input  logic [VPN2_W-1:0]   cp0_vpn2,
  input  logic [IDX_W-1:0]    cp0_index,
  input  logic [LO_W-1:0]     cp0_lo0,
  input  logic [LO_W-1:0]     cp0_lo1,
  input  logic                tlbwi,
  input  logic                tlbwr,
  input  logic                tlbp,
  input  logic                tlbr,
  output logic                tlbp_done,
  output logic                tlbp_found,
  output logic [IDX_W-1:0]    tlbp_index,
  output logic                tlbr_done,
  output logic [VPN2_W-1:0]   tlbr_vpn2,
  output logic [ASID_W-1:0]   tlbr_asid,
  output logic [LO_W-1:0]     tlbr_lo0,
  output logic [LO_W-1:0]     tlbr_lo1,
  output logic                tlb_buffer_flush
);

  tlb_entry_t [TLBNUM-1:0]       entries;
  logic [TLBNUM-1:0][VPN2_W-1:0] ent_vpn2;
  logic [TLBNUM-1:0][ASID_W-1:0] ent_asid;
  logic [TLBNUM-1:0]             ent_g;

  generate
    for (genvar k = 0; k < TLBNUM; k++) begin : g_fields
      assign ent_vpn2[k] = entries[k].vpn2;
      assign ent_asid[k] = entries[k].asid;
      assign ent_g[k]    = entries[k].g;
    end
  endgenerate

  logic             write;
  logic [IDX_W-1:0] wr_idx;

  assign write = tlbwi | tlbwr;

`ifdef TLB_RANDOM_WR_EN
  logic [IDX_W-1:0] random_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      random_idx <= IDX_W'(TLBNUM - 1);
    end else begin
      random_idx <= random_idx - IDX_W'(1);
    end
  end

  assign wr_idx = tlbwr ? random_idx : cp0_index;
`else
  assign wr_idx = cp0_index;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      entries <= '0;
    end else if (write) begin
      entries[wr_idx] <= make_entry(cp0_vpn2, cp0_asid, cp0_lo0, cp0_lo1);
    end
  end

  logic              look_found;
  logic [IDX_W-1:0]  look_index;
  logic              probe_found;
  logic [IDX_W-1:0]  probe_index;
  logic [VPN2_W-1:0] look_vpn2;

  tlb_match u_look_match (
    .ent_vpn2 (ent_vpn2),
    .ent_asid (ent_asid),
    .ent_g    (ent_g),
    .vpn2     (look_vpn2),
    .asid     (cp0_asid),
    .found    (look_found),
    .index    (look_index)
  );

  tlb_match u_probe_match (
    .ent_vpn2 (ent_vpn2),
    .ent_asid (ent_asid),
    .ent_g    (ent_g),
    .vpn2     (cp0_vpn2),
    .asid     (cp0_asid),
    .found    (probe_found),
    .index    (probe_index)
  );

  state_t           state;
  logic             src_d;
  logic             i_strobe;
  logic             d_strobe;
  logic             resp_found_q;
  logic [IDX_W-1:0] resp_index_q;
  tlb_half_t        resp_h0;
  tlb_half_t        resp_h1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      src_d        <= 1'b0;
      look_vpn2    <= '0;
      i_strobe     <= 1'b0;
      d_strobe     <= 1'b0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_h0      <= '0;
      resp_h1      <= '0;
    end else begin
      i_strobe <= 1'b0;
      d_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.d_req) begin
            src_d     <= 1'b1;
            look_vpn2 <= bus.d_vpn2;
            state     <= ST_LOOK;
          end else if (bus.i_req) begin
            src_d     <= 1'b0;
            look_vpn2 <= bus.i_vpn2;
            state     <= ST_LOOK;
          end
        end
        ST_LOOK: begin
          // A concurrent write makes this result stale; the requester is re-served later.
          if (write) begin
            state <= ST_IDLE;
          end else begin
            resp_found_q <= look_found;
            resp_index_q <= look_index;
            resp_h0      <= look_found ? entries[look_index].lo0 : '0;
            resp_h1      <= look_found ? entries[look_index].lo1 : '0;
            d_strobe     <= src_d;
            i_strobe     <= ~src_d;
            state        <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A write or reset coinciding with the strobe cycle suppresses the now-stale response.
  logic drop;
  assign drop = write | reset;

  assign bus.d_resp_valid = d_strobe & ~drop;
  assign bus.i_resp_valid = i_strobe & ~drop;
  assign bus.resp_found   = resp_found_q;
  assign bus.resp_index   = resp_index_q;
  assign bus.resp_pfn0    = resp_h0.pfn;
  assign bus.resp_c0      = resp_h0.c;
  assign bus.resp_d0      = resp_h0.d;
  assign bus.resp_v0      = resp_h0.v;
  assign bus.resp_pfn1    = resp_h1.pfn;
  assign bus.resp_c1      = resp_h1.c;
  assign bus.resp_d1      = resp_h1.d;
  assign bus.resp_v1      = resp_h1.v;

  always_ff @(posedge clk) begin
    if (reset) begin
      tlbp_done        <= 1'b0;
      tlbp_found       <= 1'b0;
      tlbp_index       <= '0;
      tlbr_done        <= 1'b0;
      tlbr_vpn2        <= '0;
      tlbr_asid        <= '0;
      tlbr_lo0         <= '0;
      tlbr_lo1         <= '0;
      tlb_buffer_flush <= 1'b0;
    end else begin
      tlbp_done        <= tlbp;
      tlbr_done        <= tlbr;
      tlb_buffer_flush <= write;
      if (tlbp) begin
        tlbp_found <= probe_found;
        tlbp_index <= probe_index;
      end
      if (tlbr) begin
        tlbr_vpn2 <= entries[cp0_index].vpn2;
        tlbr_asid <= entries[cp0_index].asid;
        tlbr_lo0  <= {entries[cp0_index].lo0, entries[cp0_index].g};
        tlbr_lo1  <= {entries[cp0_index].lo1, entries[cp0_index].g};
      end
    end
  end

endmodule
`default_nettype wire
